// File: rtl/pc_trace_buffer_if.sv
// Producer/consumer bundle for pc_trace_buffer: retire-side capture inputs,
// read-port handshake and status outputs. Clock and reset stay outside.
interface pc_trace_buffer_if #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Capture side (driven by the core)
    logic          i_valid;
    logic [31:0]   i_instruction;
    logic [31:0]   i_pc_cur;
    logic [31:0]   i_pc_next;
    logic          i_clear;

    // Read side: valid/ready, a pop happens on an edge where o_rd_valid and
    // i_rd_ready are both high; o_rd_* hold while valid is high and ready low.
    logic          i_rd_ready;
    logic          o_rd_valid;
    logic [31:0]   o_rd_pc;
    logic [31:0]   o_rd_target;
    logic [31:0]   o_rd_instr;

    // Status
    logic [CW-1:0]    o_count;
    logic             o_overflow;
    logic [CNT_W-1:0] o_dropped;

    modport master (
        output i_valid, i_instruction, i_pc_cur, i_pc_next, i_clear, i_rd_ready,
        input  o_rd_valid, o_rd_pc, o_rd_target, o_rd_instr,
        input  o_count, o_overflow, o_dropped
    );

    modport slave (
        input  i_valid, i_instruction, i_pc_cur, i_pc_next, i_clear, i_rd_ready,
        output o_rd_valid, o_rd_pc, o_rd_target, o_rd_instr,
        output o_count, o_overflow, o_dropped
    );
endinterface

// File: rtl/pc_trace_buffer.sv
// Control-flow trace buffer: records {pc, next pc, instr} on PC discontinuities
// into a FWFT circular buffer. Define PC_TRACE_ALL_EN to record every retire.
module pc_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_arst_n,
    pc_trace_buffer_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic [CNT_W-1:0] r_dropped;

    logic [31:0] r_pc_mem     [DEPTH];
    logic [31:0] r_target_mem [DEPTH];
    logic [31:0] r_instr_mem  [DEPTH];

    logic [31:0] w_seq_pc;
    logic        w_capture;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;

    // Sequential-flow check wraps modulo 2^32, so 0xFFFFFFFC -> 0 is not a jump.
    assign w_seq_pc = bus.i_pc_cur + 32'd4;

`ifdef PC_TRACE_ALL_EN
    assign w_capture = bus.i_valid;
`else
    assign w_capture = bus.i_valid && (bus.i_pc_next != w_seq_pc);
`endif

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // Clear wins over everything; a pop frees the slot a same-cycle push needs.
    assign w_pop  = !bus.i_clear && !w_empty && bus.i_rd_ready;
    assign w_push = !bus.i_clear && w_capture && (!w_full || w_pop);
    assign w_drop = !bus.i_clear && w_capture && w_full && !w_pop;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end else if (bus.i_clear) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_dropped != '1) begin
                    r_dropped <= r_dropped + 1'b1;
                end
            end
        end
    end

    // Storage is not reset; validity is carried entirely by r_count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_pc_mem[r_tail]     <= bus.i_pc_cur;
            r_target_mem[r_tail] <= bus.i_pc_next;
            r_instr_mem[r_tail]  <= bus.i_instruction;
        end
    end

    // Head fields are forced to zero when empty, which also covers reset.
    assign bus.o_rd_valid  = !w_empty;
    assign bus.o_rd_pc     = w_empty ? 32'h0 : r_pc_mem[r_head];
    assign bus.o_rd_target = w_empty ? 32'h0 : r_target_mem[r_head];
    assign bus.o_rd_instr  = w_empty ? 32'h0 : r_instr_mem[r_head];
    assign bus.o_count     = r_count;
    assign bus.o_overflow  = r_overflow;
    assign bus.o_dropped   = r_dropped;
endmodule

// File: tb/tb_pc_trace_buffer.sv
// Directed bench for pc_trace_buffer; a second small instance covers counter saturation.
module tb_pc_trace_buffer;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_tg_q[$];
    logic [31:0] exp_in_q[$];

    pc_trace_buffer_if #(.DEPTH(16), .CNT_W(16)) bus ();
    pc_trace_buffer_if #(.DEPTH(4),  .CNT_W(2))  bus_s ();

    pc_trace_buffer #(.DEPTH(16), .CNT_W(16)) dut (
        .i_clk    (clk),
        .i_arst_n (rst_n),
        .bus      (bus)
    );

    pc_trace_buffer #(.DEPTH(4), .CNT_W(2)) dut_sat (
        .i_clk    (clk),
        .i_arst_n (rst_n),
        .bus      (bus_s)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] cur, input logic [31:0] nxt,
                         input logic [31:0] ins, input logic rdy, input logic clr);
        bus.i_valid       = v;
        bus.i_pc_cur      = cur;
        bus.i_pc_next     = nxt;
        bus.i_instruction = ins;
        bus.i_rd_ready    = rdy;
        bus.i_clear       = clr;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc,
                              input logic [31:0] tg, input logic [31:0] ins);
        check({tag, "_valid"},  32'(bus.o_rd_valid), 32'd1);
        check({tag, "_pc"},     bus.o_rd_pc, pc);
        check({tag, "_target"}, bus.o_rd_target, tg);
        check({tag, "_instr"},  bus.o_rd_instr, ins);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        idle();
        bus_s.i_valid = 1'b0; bus_s.i_pc_cur = '0; bus_s.i_pc_next = '0;
        bus_s.i_instruction = '0; bus_s.i_rd_ready = 1'b0; bus_s.i_clear = 1'b0;

        // reset state
        #3;
        check("rst_valid",    32'(bus.o_rd_valid), 32'd0);
        check("rst_count",    32'(bus.o_count), 32'd0);
        check("rst_overflow", 32'(bus.o_overflow), 32'd0);
        check("rst_dropped",  32'(bus.o_dropped), 32'd0);
        check("rst_rd_pc",    bus.o_rd_pc, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_count", 32'(bus.o_count), 32'd0);

        // sequential run then one taken branch
        drive(1'b1, 32'h0, 32'h4, 32'h00000013, 1'b0, 1'b0); step();
        drive(1'b1, 32'h4, 32'h8, 32'h00000013, 1'b0, 1'b0); step();
        drive(1'b1, 32'h8, 32'h20, 32'h08000008, 1'b0, 1'b0); step();
        idle();
`ifdef PC_TRACE_ALL_EN
        check("seq_count", 32'(bus.o_count), 32'd3);
        check_head("seq_head", 32'h0, 32'h4, 32'h00000013);
`else
        check("seq_count", 32'(bus.o_count), 32'd1);
        check_head("seq_head", 32'h8, 32'h20, 32'h08000008);
`endif
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1); step(); idle();
        check("clr_count", 32'(bus.o_count), 32'd0);

        // wrap of pc+4 at the top of the address space
        drive(1'b1, 32'hFFFFFFFC, 32'h00000000, 32'h00000013, 1'b0, 1'b0); step(); idle();
`ifdef PC_TRACE_ALL_EN
        check("wrap_count", 32'(bus.o_count), 32'd1);
`else
        check("wrap_count", 32'(bus.o_count), 32'd0);
`endif
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1); step(); idle();

        // empty buffer: capture with ready in the same cycle pushes only
        drive(1'b1, 32'h100, 32'h200, 32'h0000000A, 1'b1, 1'b0); step();
        check("emp_push_count", 32'(bus.o_count), 32'd1);
        check_head("emp_push_head", 32'h100, 32'h200, 32'h0000000A);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0); step();
        check("emp_pop_count", 32'(bus.o_count), 32'd0);
        check("emp_pop_valid", 32'(bus.o_rd_valid), 32'd0);
        step();
        check("empty_ready_ignored", 32'(bus.o_count), 32'd0);
        idle();

        // 17 jumps into a 16-deep buffer, no reads
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, 32'h1000 + 32'(k) * 32'h10, 32'h8000 + 32'(k) * 32'h100,
                  32'hC0DE0000 + 32'(k), 1'b0, 1'b0);
            if (k < 16) begin
                exp_pc_q.push_back(bus.i_pc_cur);
                exp_tg_q.push_back(bus.i_pc_next);
                exp_in_q.push_back(bus.i_instruction);
            end
            step();
            if (k == 15) begin
                check("full16_count",    32'(bus.o_count), 32'd16);
                check("full16_overflow", 32'(bus.o_overflow), 32'd0);
            end
        end
        idle();
        check("ovf_count",    32'(bus.o_count), 32'd16);
        check("ovf_overflow", 32'(bus.o_overflow), 32'd1);
        check("ovf_dropped",  32'(bus.o_dropped), 32'd1);
        check_head("ovf_head", 32'h1000, 32'h8000, 32'hC0DE0000);
        step();
        check_head("hold_head", 32'h1000, 32'h8000, 32'hC0DE0000);

        // full with simultaneous capture and pop
        drive(1'b1, 32'h9000, 32'h9100, 32'h0000BEEF, 1'b1, 1'b0); step(); idle();
        void'(exp_pc_q.pop_front()); void'(exp_tg_q.pop_front()); void'(exp_in_q.pop_front());
        exp_pc_q.push_back(32'h9000); exp_tg_q.push_back(32'h9100); exp_in_q.push_back(32'h0000BEEF);
        check("fullpp_count",   32'(bus.o_count), 32'd16);
        check("fullpp_dropped", 32'(bus.o_dropped), 32'd1);
        check_head("fullpp_head", 32'h1010, 32'h8100, 32'hC0DE0001);

        // drain in order
        bus.i_rd_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check_head($sformatf("drain%0d", k), exp_pc_q.pop_front(),
                       exp_tg_q.pop_front(), exp_in_q.pop_front());
            step();
        end
        idle();
        check("drain_count", 32'(bus.o_count), 32'd0);
        check("drain_valid", 32'(bus.o_rd_valid), 32'd0);

        // clear with capture and ready while overflowed
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, 32'h2000 + 32'(k) * 32'h10, 32'h3000, 32'h0, 1'b0, 1'b0);
            step();
        end
        check("pre_clr_overflow", 32'(bus.o_overflow), 32'd1);
        drive(1'b1, 32'h4000, 32'h5000, 32'h1, 1'b1, 1'b1); step(); idle();
        check("clr_count2",    32'(bus.o_count), 32'd0);
        check("clr_overflow",  32'(bus.o_overflow), 32'd0);
        check("clr_dropped",   32'(bus.o_dropped), 32'd0);
        check("clr_valid",     32'(bus.o_rd_valid), 32'd0);

        // asynchronous reset pulse between edges
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h6000 + 32'(k) * 32'h10, 32'h7000, 32'h2, 1'b0, 1'b0);
            step();
        end
        idle();
        check("pre_arst_count", 32'(bus.o_count), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.o_rd_valid), 32'd0);
        check("arst_count", 32'(bus.o_count), 32'd0);
        check("arst_rd_pc", bus.o_rd_pc, 32'h0);
        #2 rst_n = 1'b1;
        step();
        check("post_arst_count", 32'(bus.o_count), 32'd0);

        // dropped counter saturation on a DEPTH=4, CNT_W=2 instance
        bus_s.i_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus_s.i_pc_cur  = 32'h100 + 32'(k) * 32'h40;
            bus_s.i_pc_next = 32'h800;
            step();
            if (k == 5) check("sat_dropped2", 32'(bus_s.o_dropped), 32'd2);
        end
        bus_s.i_valid = 1'b0;
        check("sat_count",    32'(bus_s.o_count), 32'd4);
        check("sat_overflow", 32'(bus_s.o_overflow), 32'd1);
        check("sat_dropped",  32'(bus_s.o_dropped), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pc_trace_buffer.md
PC_TRACE_BUFFER -- requirements
Module: pc_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, number of trace entries; SHALL be a power of two, 4..256.
REQ-002 Parameter CNT_W, default 16, width of the dropped-entry counter.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_arst_n  input  1  reset, asynchronous and active-low.
REQ-005 i_valid  input  1  core retired an instruction this cycle; sample inputs.
REQ-006 i_instruction  input  32  instruction word executed at i_pc_cur.
REQ-007 i_pc_cur  input  32  current program counter.
REQ-008 i_pc_next  input  32  program counter of the next instruction.
REQ-009 i_clear  input  1  synchronous flush of buffer, overflow flag and drop counter.
REQ-010 i_rd_ready  input  1  consumer accepts head entry.
REQ-011 o_rd_valid  output  1  head entry available.
REQ-012 o_rd_pc  output  32  head entry source PC.
REQ-013 o_rd_target  output  32  head entry next PC.
REQ-014 o_rd_instr  output  32  head entry instruction word.
REQ-015 o_count  output  $clog2(DEPTH)+1  entries currently stored.
REQ-016 o_overflow  output  1  sticky: at least one entry dropped since reset/clear.
REQ-017 o_dropped  output  CNT_W  number of dropped entries, saturating.

Function
REQ-018 Capture condition: i_valid=1 and i_pc_next != i_pc_cur + 32'd4 (modulo 2^32, so 0xFFFFFFFC->0x00000000 is sequential).
REQ-019 A captured cycle SHALL push {i_pc_cur, i_pc_next, i_instruction} at the tail on the same rising edge.
REQ-020 Storage SHALL be a registered circular array with head/tail pointers wrapping at DEPTH-1 -> 0.
REQ-021 Read port SHALL be first-word fall-through: o_rd_* driven from the head entry, o_rd_valid = (o_count != 0).
REQ-022 Pop SHALL occur when o_rd_valid=1 and i_rd_ready=1; i_rd_ready with empty buffer SHALL be ignored.
REQ-023 Push latency: entry captured at edge N SHALL appear on o_rd_* (if buffer was empty) immediately after edge N.
REQ-024 o_rd_* SHALL hold stable while o_rd_valid=1 and i_rd_ready=0.
REQ-025 Full (o_count=DEPTH) with capture and no pop: entry dropped, o_overflow set, o_dropped incremented, saturating at 2^CNT_W-1.
REQ-026 Full with simultaneous capture and pop: both SHALL succeed, o_count unchanged, nothing dropped.
REQ-027 Empty with simultaneous capture and i_rd_ready: push only; the new entry is popped no earlier than the next edge.
REQ-028 i_clear SHALL have priority over push and pop: o_count=0, pointers=0, o_overflow=0, o_dropped=0 after the edge; no capture that cycle.
REQ-029 o_count SHALL change by +1, -1 or 0 per cycle except on i_clear/reset.

Reset
REQ-030 i_arst_n=0 SHALL immediately force pointers=0, o_count=0, o_rd_valid=0, o_overflow=0, o_dropped=0 irrespective of i_clk.
REQ-031 o_rd_pc, o_rd_target, o_rd_instr SHALL read 32'h0 while in reset; array contents need not be cleared.
REQ-032 Reset asserted mid-operation SHALL discard all entries; no push or pop SHALL occur on the edge at which reset releases, provided i_valid=0.

Configuration
REQ-033 Macro PC_TRACE_ALL_EN: when defined, capture condition SHALL be i_valid=1 alone (full instruction trace).
REQ-034 Without PC_TRACE_ALL_EN, capture SHALL follow REQ-018 (discontinuities only: branches, jumps, exceptions).

Verification
REQ-035 Sequential run pc 0x0,0x4,0x8 with i_valid=1, then pc_cur=0x8 pc_next=0x20 instr=0x08000008 -> exactly one entry {0x8,0x20,0x08000008}, o_count=1.
REQ-036 DEPTH=16, 17 jumps, i_rd_ready=0 -> o_count=16, o_overflow=1, o_dropped=1; the 16 oldest entries read back in order.
REQ-037 Full buffer, capture and i_rd_ready=1 same cycle -> o_count stays 16, o_dropped unchanged, head advances by one.
REQ-038 pc_cur=0xFFFFFFFC pc_next=0x00000000 -> no capture; with PC_TRACE_ALL_EN defined -> captured.
REQ-039 3 entries stored, i_arst_n pulsed low for 3 ns between edges -> o_rd_valid=0, o_count=0 before the next edge.
REQ-040 i_clear with capture and i_rd_ready in same cycle while o_overflow=1 -> o_count=0, o_overflow=0, o_dropped=0.
